// File: rtl/load_store_queue.sv
//==============================================================================
// Module      : load_store_queue
// Description : Circular load/store queue with operand wake-up from the CDB,
//               in-order memory issue (one access outstanding), store commit
//               tracking, flush recovery and sized/sign-extended load results.
//               Optional macro LSQ_SELF_WAKE_EN: completing loads also wake
//               queue entries internally alongside res_en.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module load_store_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4,
    parameter int DAT_W = 32,
    parameter int ADR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             iss_en,
    input  logic             iss_ld,
    input  logic [1:0]       iss_len,
    input  logic             iss_sext,
    input  logic [TAG_W-1:0] iss_qj,
    input  logic [DAT_W-1:0] iss_vj,
    input  logic [TAG_W-1:0] iss_qk,
    input  logic [DAT_W-1:0] iss_vk,
    input  logic [DAT_W-1:0] iss_imm,
    input  logic [TAG_W-1:0] iss_tag,
    output logic             full,
    input  logic             cdb_en,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [DAT_W-1:0] cdb_val,
    input  logic             cmt_en,
    input  logic [TAG_W-1:0] cmt_tag,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       mem_len,
    output logic [ADR_W-1:0] mem_adr,
    output logic [DAT_W-1:0] mem_wdat,
    input  logic             mem_ack,
    input  logic [DAT_W-1:0] mem_rdat,
    output logic             res_en,
    output logic [TAG_W-1:0] res_tag,
    output logic [DAT_W-1:0] res_val
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Entry storage
    logic             e_val_q  [DEPTH];
    logic             e_ld_q   [DEPTH];
    logic             e_cmt_q  [DEPTH];
    logic [1:0]       e_len_q  [DEPTH];
    logic             e_sext_q [DEPTH];
    logic [TAG_W-1:0] e_qj_q   [DEPTH];
    logic [DAT_W-1:0] e_vj_q   [DEPTH];
    logic [TAG_W-1:0] e_qk_q   [DEPTH];
    logic [DAT_W-1:0] e_vk_q   [DEPTH];
    logic [DAT_W-1:0] e_imm_q  [DEPTH];
    logic [TAG_W-1:0] e_tag_q  [DEPTH];

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic             kill_q, kill_d;
    logic             mem_req_q, res_en_q;
    logic             res_en_d;
    logic [TAG_W-1:0] res_tag_d;
    logic [DAT_W-1:0] res_val_d;

    logic             w_pop, w_push, w_ready, w_launch;
    logic [PW-1:0]    w_base;
    logic [CW-1:0]    w_left, w_ccnt, w_keep;
    logic [DEPTH-1:0] w_discard;
    logic [DAT_W-1:0] w_sum;

    // Second wake-up source: the completing load itself, when enabled
    logic             w_wk_en;
    logic [TAG_W-1:0] w_wk_tag;
    logic [DAT_W-1:0] w_wk_val;
`ifdef LSQ_SELF_WAKE_EN
    assign w_wk_en  = res_en_d;
    assign w_wk_tag = res_tag_d;
    assign w_wk_val = res_val_d;
`else
    assign w_wk_en  = 1'b0;
    assign w_wk_tag = '0;
    assign w_wk_val = '0;
`endif

    function automatic logic hit(input logic [TAG_W-1:0] q, input logic ven,
                                 input logic [TAG_W-1:0] t);
        return ven && (q != '0) && (q == t);
    endfunction

    function automatic logic [DAT_W-1:0] extend(input logic [DAT_W-1:0] d,
                                                input logic [1:0] len, input logic sx);
        case (len)
            2'd0:    return {{(DAT_W-8){sx & d[7]}}, d[7:0]};
            2'd1:    return {{(DAT_W-16){sx & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign mem_req = mem_req_q & en;
    assign res_en  = res_en_q & en;
    assign w_sum   = e_vj_q[head_q] + e_imm_q[head_q];

    // Next-state control: pop/push, flush recovery, FSM and result formation
    always_comb begin : p_ctl
        logic [PW-1:0] idx;
        logic          run;
        logic [PW-1:0] off;
        idx      = '0;
        off      = '0;
        run      = 1'b1;
        w_pop    = (state_q == S_WAIT) && mem_ack;
        w_base   = w_pop ? head_q + PW'(1) : head_q;
        w_left   = w_pop ? count_q - CW'(1) : count_q;
        // Committed stores form a contiguous run starting at the (post-pop) head
        w_ccnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = w_base + PW'(i);
            if (run && (CW'(i) < w_left) && e_val_q[idx] && !e_ld_q[idx] && e_cmt_q[idx])
                w_ccnt = w_ccnt + CW'(1);
            else
                run = 1'b0;
        end
        w_ready  = e_val_q[head_q] && (e_qj_q[head_q] == '0) &&
                   (e_ld_q[head_q] || ((e_qk_q[head_q] == '0) && e_cmt_q[head_q]));
        w_launch = (state_q == S_IDLE) && w_ready && !flush;
        w_push   = iss_en && (!full || w_pop) && !flush;
        // An in-flight load survives a flush as a killed entry so its ack can pop it
        w_keep   = ((state_q == S_WAIT) && !w_pop && e_ld_q[head_q]) ? CW'(1) : w_ccnt;
        for (int i = 0; i < DEPTH; i++) begin
            off          = PW'(i) - w_base;
            w_discard[i] = ({1'b0, off} >= w_keep);
        end
        head_d   = w_base;
        tail_d   = flush ? w_base + w_keep[PW-1:0] : (w_push ? tail_q + PW'(1) : tail_q);
        count_d  = flush ? w_keep
                         : count_q - (w_pop ? CW'(1) : CW'(0)) + (w_push ? CW'(1) : CW'(0));
        state_d  = w_launch ? S_WAIT : (w_pop ? S_IDLE : state_q);
        kill_d   = w_pop ? 1'b0
                 : ((flush && (state_q == S_WAIT) && e_ld_q[head_q]) ? 1'b1 : kill_q);
        res_en_d  = w_pop && e_ld_q[head_q] && !kill_q && !flush;
        res_tag_d = e_tag_q[head_q];
        res_val_d = extend(mem_rdat, e_len_q[head_q], e_sext_q[head_q]);
    end

    // Entry array: wake-up, commit marking, flush discard, pop and push
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_val_q[i] <= 1'b0;
                e_ld_q[i]  <= 1'b0;
                e_cmt_q[i] <= 1'b0;
            end
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_val_q[i]) begin
                    if (hit(e_qj_q[i], cdb_en, cdb_tag)) begin
                        e_qj_q[i] <= '0; e_vj_q[i] <= cdb_val;
                    end else if (hit(e_qj_q[i], w_wk_en, w_wk_tag)) begin
                        e_qj_q[i] <= '0; e_vj_q[i] <= w_wk_val;
                    end
                    if (hit(e_qk_q[i], cdb_en, cdb_tag)) begin
                        e_qk_q[i] <= '0; e_vk_q[i] <= cdb_val;
                    end else if (hit(e_qk_q[i], w_wk_en, w_wk_tag)) begin
                        e_qk_q[i] <= '0; e_vk_q[i] <= w_wk_val;
                    end
                    if (cmt_en && !e_ld_q[i] && (e_tag_q[i] == cmt_tag))
                        e_cmt_q[i] <= 1'b1;
                end
                if (flush && w_discard[i])
                    e_val_q[i] <= 1'b0;
            end
            if (w_pop)
                e_val_q[head_q] <= 1'b0;
            if (w_push) begin
                e_val_q[tail_q]  <= 1'b1;
                e_ld_q[tail_q]   <= iss_ld;
                e_cmt_q[tail_q]  <= 1'b0;
                e_len_q[tail_q]  <= iss_len;
                e_sext_q[tail_q] <= iss_sext;
                e_imm_q[tail_q]  <= iss_imm;
                e_tag_q[tail_q]  <= iss_tag;
                e_qj_q[tail_q]   <= iss_qj;
                e_vj_q[tail_q]   <= iss_vj;
                e_qk_q[tail_q]   <= iss_qk;
                e_vk_q[tail_q]   <= iss_vk;
                if (hit(iss_qj, cdb_en, cdb_tag)) begin
                    e_qj_q[tail_q] <= '0; e_vj_q[tail_q] <= cdb_val;
                end else if (hit(iss_qj, w_wk_en, w_wk_tag)) begin
                    e_qj_q[tail_q] <= '0; e_vj_q[tail_q] <= w_wk_val;
                end
                if (hit(iss_qk, cdb_en, cdb_tag)) begin
                    e_qk_q[tail_q] <= '0; e_vk_q[tail_q] <= cdb_val;
                end else if (hit(iss_qk, w_wk_en, w_wk_tag)) begin
                    e_qk_q[tail_q] <= '0; e_vk_q[tail_q] <= w_wk_val;
                end
            end
        end
    end

    // Pointers, FSM, memory launch registers and registered load result
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            kill_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we    <= 1'b0;
            mem_len   <= '0;
            mem_adr   <= '0;
            mem_wdat  <= '0;
            res_en_q  <= 1'b0;
            res_tag   <= '0;
            res_val   <= '0;
        end else if (!en) begin
            mem_req_q <= 1'b0;
            res_en_q  <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
            kill_q    <= kill_d;
            mem_req_q <= w_launch;
            if (w_launch) begin
                mem_we   <= !e_ld_q[head_q];
                mem_len  <= e_len_q[head_q];
                mem_adr  <= ADR_W'(w_sum);
                mem_wdat <= e_vk_q[head_q];
            end
            res_en_q <= res_en_d;
            if (res_en_d) begin
                res_tag <= res_tag_d;
                res_val <= res_val_d;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_queue.sv
//==============================================================================
// Module      : tb_load_store_queue
// Description : Directed self-checking bench for load_store_queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_load_store_queue;

    logic        clk = 1'b0;
    logic        rst, en, flush, iss_en, iss_ld, iss_sext;
    logic [1:0]  iss_len;
    logic [3:0]  iss_qj, iss_qk, iss_tag, cdb_tag, cmt_tag;
    logic [31:0] iss_vj, iss_vk, iss_imm, cdb_val, mem_rdat;
    logic        cdb_en, cmt_en, mem_ack;
    logic        full, mem_req, mem_we, res_en;
    logic [1:0]  mem_len;
    logic [31:0] mem_adr, mem_wdat, res_val;
    logic [3:0]  res_tag;

    int n_cmp = 0;
    int n_err = 0;

    load_store_queue #(.DEPTH(8), .TAG_W(4), .DAT_W(32), .ADR_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .iss_en(iss_en), .iss_ld(iss_ld), .iss_len(iss_len), .iss_sext(iss_sext),
        .iss_qj(iss_qj), .iss_vj(iss_vj), .iss_qk(iss_qk), .iss_vk(iss_vk),
        .iss_imm(iss_imm), .iss_tag(iss_tag), .full(full),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .cmt_en(cmt_en), .cmt_tag(cmt_tag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_adr(mem_adr),
        .mem_wdat(mem_wdat), .mem_ack(mem_ack), .mem_rdat(mem_rdat),
        .res_en(res_en), .res_tag(res_tag), .res_val(res_val)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic ld, input logic [1:0] len, input logic sx,
                         input logic [3:0] qj, input logic [31:0] vj,
                         input logic [3:0] qk, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [3:0] tag);
        iss_ld = ld; iss_len = len; iss_sext = sx; iss_qj = qj; iss_vj = vj;
        iss_qk = qk; iss_vk = vk; iss_imm = imm; iss_tag = tag; iss_en = 1'b1;
        tick();
        iss_en = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        mem_ack = 1'b1; mem_rdat = d;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic commit(input logic [3:0] t);
        cmt_en = 1'b1; cmt_tag = t;
        tick();
        cmt_en = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v);
        cdb_en = 1'b1; cdb_tag = t; cdb_val = v;
        tick();
        cdb_en = 1'b0;
    endtask

    // Bounded wait for a launch; returns the number of cycles waited
    task automatic wait_req(output int cyc);
        cyc = 0;
        while (!mem_req && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    // Observe a window of cycles; report whether mem_req / res_en appeared
    task automatic quiet(input int n, output logic req_seen, output logic res_seen);
        req_seen = 1'b0; res_seen = 1'b0;
        repeat (n) begin
            tick();
            if (mem_req) req_seen = 1'b1;
            if (res_en)  res_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %0b want 0", full); end
        n_cmp++; if (mem_req !== 1'b0 || res_en !== 1'b0) begin n_err++; $display("FAIL rst_pulses: req %0b res %0b want 0 0", mem_req, res_en); end
        n_cmp++; if (mem_adr !== 32'h0 || res_val !== 32'h0) begin n_err++; $display("FAIL rst_data: adr %h val %h want 0 0", mem_adr, res_val); end
        rst = 1'b0;
        tick();
        n_cmp++; if (full !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL post_rst: full %0b req %0b want 0 0", full, mem_req); end
    endtask

    task automatic test_load_word();
        int c;
        issue(1'b1, 2'd2, 1'b0, 4'd0, 32'h100, 4'd0, 32'h0, 32'h4, 4'd3);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL lw_early: req %0b want 0", mem_req); end
        wait_req(c);
        n_cmp++; if (mem_req !== 1'b1 || c != 1) begin n_err++; $display("FAIL lw_launch: req %0b after %0d want 1 after 1", mem_req, c); end
        n_cmp++; if (mem_adr !== 32'h104 || mem_len !== 2'd2 || mem_we !== 1'b0) begin n_err++; $display("FAIL lw_access: adr %h len %0d we %0b want 104 2 0", mem_adr, mem_len, mem_we); end
        ack(32'hDEADBEEF);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL lw_pulse: req %0b want 0", mem_req); end
        n_cmp++; if (res_en !== 1'b1 || res_tag !== 4'd3 || res_val !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_result: en %0b tag %0d val %h want 1 3 deadbeef", res_en, res_tag, res_val); end
        tick();
        n_cmp++; if (res_en !== 1'b0) begin n_err++; $display("FAIL lw_res_pulse: en %0b want 0", res_en); end
    endtask

    task automatic test_load_sized();
        logic [1:0]  len [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        sx  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] rd  [4] = '{32'hABCDEF80, 32'hABCDEF80, 32'h00008001, 32'h12348001};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
        int c;
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, len[k], sx[k], 4'd0, 32'h200, 4'd0, 32'h0, 32'h0, 4'd4);
            wait_req(c);
            n_cmp++; if (mem_req !== 1'b1 || mem_len !== len[k]) begin n_err++; $display("FAIL sized_req%0d: req %0b len %0d want 1 %0d", k, mem_req, mem_len, len[k]); end
            ack(rd[k]);
            n_cmp++; if (res_en !== 1'b1 || res_val !== exp[k]) begin n_err++; $display("FAIL sized_val%0d: en %0b val %h want 1 %h", k, res_en, res_val, exp[k]); end
        end
    endtask

    task automatic test_store_commit();
        int c; logic rq, rs;
        issue(1'b0, 2'd2, 1'b0, 4'd0, 32'h300, 4'd5, 32'h0, 32'h8, 4'd6);
        quiet(4, rq, rs);
        n_cmp++; if (rq !== 1'b0) begin n_err++; $display("FAIL st_wait_qk: req seen %0b want 0", rq); end
        cdb(4'd5, 32'h55);
        quiet(3, rq, rs);
        n_cmp++; if (rq !== 1'b0) begin n_err++; $display("FAIL st_wait_cmt: req seen %0b want 0", rq); end
        commit(4'd6);
        wait_req(c);
        n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdat !== 32'h55 || mem_adr !== 32'h308) begin n_err++; $display("FAIL st_launch: req %0b we %0b wdat %h adr %h want 1 1 55 308", mem_req, mem_we, mem_wdat, mem_adr); end
        ack(32'h0);
        n_cmp++; if (res_en !== 1'b0) begin n_err++; $display("FAIL st_no_res: en %0b want 0", res_en); end
    endtask

    task automatic test_full();
        logic [3:0] exp [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10};
        int c; logic rq, rs;
        for (int k = 0; k < 8; k++) begin
            issue(1'b1, 2'd2, 1'b0, 4'd15, 32'h1000, 4'd0, 32'h0, 32'(4 * k), 4'(k + 1));
            if (k == 6) begin
                n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL full_at7: got %0b want 0", full); end
            end
        end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_at8: got %0b want 1", full); end
        issue(1'b1, 2'd2, 1'b0, 4'd0, 32'h9000, 4'd0, 32'h0, 32'h0, 4'd9);
        n_cmp++; if (full !== 1'b1 || mem_req !== 1'b0) begin n_err++; $display("FAIL full_drop: full %0b req %0b want 1 0", full, mem_req); end
        cdb(4'd15, 32'h2000);
        wait_req(c);
        n_cmp++; if (mem_req !== 1'b1 || mem_adr !== 32'h2000) begin n_err++; $display("FAIL full_first: req %0b adr %h want 1 2000", mem_req, mem_adr); end
        // Push in the same cycle as the ack pops the head
        iss_ld = 1'b1; iss_len = 2'd2; iss_sext = 1'b0; iss_qj = 4'd0; iss_vj = 32'h3000;
        iss_qk = 4'd0; iss_vk = 32'h0; iss_imm = 32'h0; iss_tag = 4'd10; iss_en = 1'b1;
        mem_ack = 1'b1; mem_rdat = 32'h11;
        tick();
        iss_en = 1'b0; mem_ack = 1'b0;
        n_cmp++; if (full !== 1'b1 || res_en !== 1'b1 || res_tag !== 4'd1) begin n_err++; $display("FAIL full_pushpop: full %0b en %0b tag %0d want 1 1 1", full, res_en, res_tag); end
        for (int j = 0; j < 8; j++) begin
            wait_req(c);
            n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL drain_req%0d: got %0b want 1", j, mem_req); end
            ack(32'(j));
            n_cmp++; if (res_en !== 1'b1 || res_tag !== exp[j]) begin n_err++; $display("FAIL drain_tag%0d: en %0b tag %0d want 1 %0d", j, res_en, res_tag, exp[j]); end
        end
        quiet(5, rq, rs);
        n_cmp++; if (rq !== 1'b0 || full !== 1'b0) begin n_err++; $display("FAIL drain_empty: req %0b full %0b want 0 0", rq, full); end
    endtask

    task automatic test_flush();
        int c; logic rq, rs;
        issue(1'b0, 2'd2, 1'b0, 4'd0, 32'h400, 4'd0, 32'hA1, 32'h0, 4'd1);
        issue(1'b0, 2'd2, 1'b0, 4'd0, 32'h404, 4'd0, 32'hB2, 32'h0, 4'd2);
        commit(4'd1);
        commit(4'd2);
        wait_req(c);
        n_cmp++; if (mem_req !== 1'b1 || mem_adr !== 32'h400 || mem_wdat !== 32'hA1 || mem_we !== 1'b1) begin n_err++; $display("FAIL fl_storeA: req %0b adr %h wdat %h we %0b want 1 400 a1 1", mem_req, mem_adr, mem_wdat, mem_we); end
        for (int k = 0; k < 3; k++) issue(1'b1, 2'd2, 1'b0, 4'd0, 32'h480, 4'd0, 32'h0, 32'h0, 4'(3 + k));
        flush = 1'b1; tick(); flush = 1'b0;
        // Two stores remain, so exactly six more pushes fill the queue
        for (int k = 0; k < 6; k++) begin
            issue(1'b1, 2'd2, 1'b0, 4'd0, 32'h4C0, 4'd0, 32'h0, 32'h0, 4'(6 + k));
            if (k == 4) begin
                n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL fl_count7: full %0b want 0", full); end
            end
        end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fl_count8: full %0b want 1", full); end
        flush = 1'b1; iss_en = 1'b1; tick(); flush = 1'b0; iss_en = 1'b0;
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL fl_reflush: full %0b want 0", full); end
        ack(32'h0);
        n_cmp++; if (res_en !== 1'b0) begin n_err++; $display("FAIL fl_ackA: res_en %0b want 0", res_en); end
        wait_req(c);
        n_cmp++; if (mem_req !== 1'b1 || mem_adr !== 32'h404 || mem_wdat !== 32'hB2 || mem_we !== 1'b1) begin n_err++; $display("FAIL fl_storeB: req %0b adr %h wdat %h we %0b want 1 404 b2 1", mem_req, mem_adr, mem_wdat, mem_we); end
        ack(32'h0);
        quiet(6, rq, rs);
        n_cmp++; if (rq !== 1'b0 || rs !== 1'b0 || res_en !== 1'b0) begin n_err++; $display("FAIL fl_nomore: req %0b res %0b want 0 0", rq, rs); end
    endtask

    task automatic test_flush_load_wait();
        int c;
        issue(1'b1, 2'd2, 1'b0, 4'd0, 32'h500, 4'd0, 32'h0, 32'h0, 4'd7);
        wait_req(c);
        flush = 1'b1; tick(); flush = 1'b0;
        ack(32'h1234);
        n_cmp++; if (res_en !== 1'b0) begin n_err++; $display("FAIL flw_suppress: res_en %0b want 0", res_en); end
        tick();
        issue(1'b1, 2'd2, 1'b0, 4'd0, 32'h504, 4'd0, 32'h0, 32'h0, 4'd8);
        wait_req(c);
        n_cmp++; if (mem_req !== 1'b1 || mem_adr !== 32'h504) begin n_err++; $display("FAIL flw_next_req: req %0b adr %h want 1 504", mem_req, mem_adr); end
        ack(32'h5678);
        n_cmp++; if (res_en !== 1'b1 || res_tag !== 4'd8 || res_val !== 32'h5678) begin n_err++; $display("FAIL flw_next_res: en %0b tag %0d val %h want 1 8 5678", res_en, res_tag, res_val); end
    endtask

    task automatic test_idle_ack_enable();
        int c; logic rq, rs;
        ack(32'hFFFF);
        n_cmp++; if (res_en !== 1'b0) begin n_err++; $display("FAIL idle_ack: res_en %0b want 0", res_en); end
        en = 1'b0;
        issue(1'b1, 2'd2, 1'b0, 4'd0, 32'h5F0, 4'd0, 32'h0, 32'h0, 4'd11);
        en = 1'b1;
        quiet(5, rq, rs);
        n_cmp++; if (rq !== 1'b0) begin n_err++; $display("FAIL en_freeze: req seen %0b want 0", rq); end
        issue(1'b1, 2'd2, 1'b0, 4'd0, 32'h600, 4'd0, 32'h0, 32'h0, 4'd12);
        wait_req(c);
        n_cmp++; if (mem_req !== 1'b1 || mem_adr !== 32'h600) begin n_err++; $display("FAIL en_next_req: req %0b adr %h want 1 600", mem_req, mem_adr); end
        ack(32'h66);
        n_cmp++; if (res_en !== 1'b1 || res_tag !== 4'd12) begin n_err++; $display("FAIL en_next_res: en %0b tag %0d want 1 12", res_en, res_tag); end
    endtask

    task automatic test_self_wake();
        int c; logic rq, rs;
        issue(1'b1, 2'd2, 1'b0, 4'd0, 32'h700, 4'd0, 32'h0, 32'h0, 4'd2);
        issue(1'b0, 2'd2, 1'b0, 4'd0, 32'h710, 4'd2, 32'h0, 32'h0, 4'd9);
        wait_req(c);
        n_cmp++; if (mem_req !== 1'b1 || mem_adr !== 32'h700 || mem_we !== 1'b0) begin n_err++; $display("FAIL sw_load_req: req %0b adr %h we %0b want 1 700 0", mem_req, mem_adr, mem_we); end
        commit(4'd9);
        ack(32'h77);
        n_cmp++; if (res_en !== 1'b1 || res_tag !== 4'd2) begin n_err++; $display("FAIL sw_load_res: en %0b tag %0d want 1 2", res_en, res_tag); end
`ifndef LSQ_SELF_WAKE_EN
        quiet(5, rq, rs);
        n_cmp++; if (rq !== 1'b0) begin n_err++; $display("FAIL sw_no_self_wake: req seen %0b want 0", rq); end
        cdb(4'd2, 32'h77);
`else
        rq = 1'b0; rs = 1'b0;
`endif
        wait_req(c);
        n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdat !== 32'h77 || mem_adr !== 32'h710) begin n_err++; $display("FAIL sw_store: req %0b we %0b wdat %h adr %h want 1 1 77 710", mem_req, mem_we, mem_wdat, mem_adr); end
        ack(32'h0);
    endtask

    task automatic test_reset_inflight();
        int c; logic rq, rs;
        issue(1'b0, 2'd2, 1'b0, 4'd0, 32'h800, 4'd0, 32'h99, 32'h0, 4'd13);
        commit(4'd13);
        wait_req(c);
        n_cmp++; if (mem_req !== 1'b1 || mem_adr !== 32'h800) begin n_err++; $display("FAIL ri_launch: req %0b adr %h want 1 800", mem_req, mem_adr); end
        rst = 1'b1; tick();
        n_cmp++; if (mem_we !== 1'b0 || mem_len !== 2'd0 || mem_adr !== 32'h0 || mem_wdat !== 32'h0) begin n_err++; $display("FAIL ri_mem_zero: we %0b len %0d adr %h wdat %h want 0 0 0 0", mem_we, mem_len, mem_adr, mem_wdat); end
        n_cmp++; if (res_tag !== 4'd0 || res_val !== 32'h0 || full !== 1'b0) begin n_err++; $display("FAIL ri_res_zero: tag %0d val %h full %0b want 0 0 0", res_tag, res_val, full); end
        rst = 1'b0; tick();
        ack(32'hBAD);
        n_cmp++; if (res_en !== 1'b0) begin n_err++; $display("FAIL ri_late_ack: res_en %0b want 0", res_en); end
        quiet(5, rq, rs);
        n_cmp++; if (rq !== 1'b0 || rs !== 1'b0) begin n_err++; $display("FAIL ri_quiet: req %0b res %0b want 0 0", rq, rs); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; iss_en = 1'b0; iss_ld = 1'b0; iss_sext = 1'b0;
        iss_len = 2'd0; iss_qj = '0; iss_qk = '0; iss_tag = '0; iss_vj = '0; iss_vk = '0;
        iss_imm = '0; cdb_en = 1'b0; cdb_tag = '0; cdb_val = '0; cmt_en = 1'b0;
        cmt_tag = '0; mem_ack = 1'b0; mem_rdat = '0;
        test_reset();
        test_load_word();
        test_load_sized();
        test_store_commit();
        test_full();
        test_flush();
        test_flush_load_wait();
        test_idle_ack_enable();
        test_self_wake();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
